traffic_display_driver: RTL and testbench

- Output stage directly downstream of the traffic-light controller; consumes its four BCD countdown digits and its two road-green requests.
- Multiplexes the four digits onto one shared 7-segment bus, blanking code 4'b1111 (manual/override mode).
- Converts the raw green requests into interlocked red/amber/green lamp drives, inserting a fixed amber phase and an all-red gap between roads.

---
 rtl/traffic_display_driver.sv | 168 ++++++++++++++++
 tb/tb_traffic_display_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_display_driver.sv
// Traffic display driver: 4-digit 7-segment scan plus interlocked lamp FSM
// fed from a registered snapshot of the traffic controller outputs.
module traffic_display_driver #(
  parameter int SCAN_DIV     = 1,
  parameter int AMBER_CYCLES = 3
) (
  input  logic       clock,
  input  logic       R,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       A_Light,
  input  logic       B_Light,
  output logic [6:0] seg,
  output logic [3:0] dig_en,
  output logic       A_Red,
  output logic       A_Amber,
  output logic       A_Green,
  output logic       B_Red,
  output logic       B_Amber,
  output logic       B_Green
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (AMBER_CYCLES > 1) ? $clog2(AMBER_CYCLES) : 1;

  typedef enum logic [2:0] {
    ALL_RED,
    A_GO,
    A_AMB,
    B_GO,
    B_AMB
  } state_t;

  logic [3:0] r_al, r_ah, r_bl, r_bh;
  logic       r_ga, r_gb;

  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [3:0]    r_dig_en;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_digit;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  function automatic logic [6:0] f_dec(input logic [3:0] d);
    case (d)
      4'd0:    f_dec = 7'b1111110;
      4'd1:    f_dec = 7'b0110000;
      4'd2:    f_dec = 7'b1101101;
      4'd3:    f_dec = 7'b1111001;
      4'd4:    f_dec = 7'b0110011;
      4'd5:    f_dec = 7'b1011011;
      4'd6:    f_dec = 7'b1011111;
      4'd7:    f_dec = 7'b1110000;
      4'd8:    f_dec = 7'b1111111;
      4'd9:    f_dec = 7'b1111011;
      4'hF:    f_dec = 7'b0000000;
      default: f_dec = 7'b0000001;
    endcase
  endfunction

  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      r_al <= 4'hF;
      r_ah <= 4'hF;
      r_bl <= 4'hF;
      r_bh <= 4'hF;
      r_ga <= 1'b0;
      r_gb <= 1'b0;
    end else begin
      r_al <= A_Time_L;
      r_ah <= A_Time_H;
      r_bl <= B_Time_L;
      r_bh <= B_Time_H;
      r_ga <= A_Light;
      r_gb <= B_Light;
    end
  end

  assign w_wrap    = (r_div == DW'(SCAN_DIV - 1));
  assign w_idx_nxt = r_idx + 2'd1;

  always_comb begin
    w_digit = r_al;
    unique case (w_idx_nxt)
      2'd0: w_digit = r_al;
      2'd1: w_digit = r_ah;
      2'd2: w_digit = r_bl;
      2'd3: w_digit = r_bh;
    endcase
  end

  // enable and segments load together so they always name the same digit
  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      r_div    <= '0;
      r_idx    <= 2'd0;
      r_dig_en <= 4'b0001;
      r_seg    <= 7'b0000000;
    end else if (w_wrap) begin
      r_div    <= '0;
      r_idx    <= w_idx_nxt;
      r_dig_en <= 4'b0001 << w_idx_nxt;
      r_seg    <= f_dec(w_digit);
    end else begin
      r_div    <= r_div + 1'b1;
    end
  end

  assign seg    = r_seg;
  assign dig_en = r_dig_en;

  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      r_state <= ALL_RED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ALL_RED: begin
        if (r_ga && !r_gb) w_state_nxt = A_GO;
        else if (r_gb && !r_ga) w_state_nxt = B_GO;
      end
      A_GO: begin
        if (!r_ga) begin
          w_state_nxt = A_AMB;
          w_cnt_nxt   = CW'(AMBER_CYCLES - 1);
        end
      end
      A_AMB: begin
        if (r_cnt == '0) w_state_nxt = ALL_RED;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      B_GO: begin
        if (!r_gb) begin
          w_state_nxt = B_AMB;
          w_cnt_nxt   = CW'(AMBER_CYCLES - 1);
        end
      end
      B_AMB: begin
        if (r_cnt == '0) w_state_nxt = ALL_RED;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_state_nxt = ALL_RED;
    endcase
  end

  assign A_Green = (r_state == A_GO);
  assign A_Amber = (r_state == A_AMB);
  assign A_Red   = !(A_Green || A_Amber);
  assign B_Green = (r_state == B_GO);
  assign B_Amber = (r_state == B_AMB);
  assign B_Red   = !(B_Green || B_Amber);

endmodule

// File: tb/tb_traffic_display_driver.sv
// Bench for traffic_display_driver: directed lamp/scan cases then random
// traffic, checked against a behavioural road/display model.
module tb_traffic_display_driver;

  localparam int AMB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] al, ah, bl, bh;
  logic       ga, gb;

  logic [6:0] seg1, seg3;
  logic [3:0] dig1, dig3;
  logic       ar1, aa1, ag1, br1, ba1, bg1;
  logic       ar3, aa3, ag3, br3, ba3, bg3;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] SEGT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000
  };

  always #5 clk = ~clk;

  traffic_display_driver #(.SCAN_DIV(1), .AMBER_CYCLES(AMB)) u_dut1 (
    .clock(clk), .R(rst),
    .A_Time_L(al), .A_Time_H(ah), .B_Time_L(bl), .B_Time_H(bh),
    .A_Light(ga), .B_Light(gb),
    .seg(seg1), .dig_en(dig1),
    .A_Red(ar1), .A_Amber(aa1), .A_Green(ag1),
    .B_Red(br1), .B_Amber(ba1), .B_Green(bg1)
  );

  traffic_display_driver #(.SCAN_DIV(3), .AMBER_CYCLES(AMB)) u_dut3 (
    .clock(clk), .R(rst),
    .A_Time_L(al), .A_Time_H(ah), .B_Time_L(bl), .B_Time_H(bh),
    .A_Light(ga), .B_Light(gb),
    .seg(seg3), .dig_en(dig3),
    .A_Red(ar3), .A_Amber(aa3), .A_Green(ag3),
    .B_Red(br3), .B_Amber(ba3), .B_Green(bg3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // road model: which road is green, which is amber, amber clocks left
  int   m_green = 0;
  int   m_amb   = 0;
  int   m_left  = 0;
  logic m_sa    = 1'b0;
  logic m_sb    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_green = 0; m_amb = 0; m_left = 0;
      m_sa = 1'b0; m_sb = 1'b0;
    end else begin
      if (m_amb != 0) begin
        m_left--;
        if (m_left == 0) m_amb = 0;
      end else if (m_green == 1) begin
        if (!m_sa) begin m_green = 0; m_amb = 1; m_left = AMB; end
      end else if (m_green == 2) begin
        if (!m_sb) begin m_green = 0; m_amb = 2; m_left = AMB; end
      end else if (m_sa && !m_sb) m_green = 1;
      else if (m_sb && !m_sa) m_green = 2;
      m_sa = ga;
      m_sb = gb;
    end
  end

  function automatic logic [5:0] m_lamps();
    logic ag_, aa_, bg_, ba_;
    ag_ = (m_green == 1); aa_ = (m_amb == 1);
    bg_ = (m_green == 2); ba_ = (m_amb == 2);
    return {!(ag_ || aa_), aa_, ag_, !(bg_ || ba_), ba_, bg_};
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] dsel(input logic [3:0] d);
    case (d)
      4'b0001: return al;
      4'b0010: return ah;
      4'b0100: return bl;
      4'b1000: return bh;
      default: return 4'hF;
    endcase
  endfunction

  logic [3:0]  p1, p3;
  logic [15:0] lastdig;
  int          run3  = 0;
  bit          first3 = 1'b1;
  int          stab  = 0;

  always @(negedge clk) begin
    chk("lamps1", {ar1, aa1, ag1, br1, ba1, bg1}, m_lamps());
    chk("lamps3", {ar3, aa3, ag3, br3, ba3, bg3}, m_lamps());
    if (rst) begin
      chk("rst_dig1", dig1, 4'b0001);
      chk("rst_seg1", seg1, 7'b0);
      chk("rst_dig3", dig3, 4'b0001);
      chk("rst_seg3", seg3, 7'b0);
      stab   = 0;
      run3   = 0;
      first3 = 1'b1;
    end else begin
      chk("rot1", dig1, rotl(p1));
      if (dig3 != p3) begin
        chk("rot3", dig3, rotl(p3));
        if (!first3) chk("hold3", run3, 3);
        first3 = 1'b0;
        run3   = 1;
      end else run3++;
      if ({al, ah, bl, bh} == lastdig) stab++;
      else stab = 0;
      if (stab >= 5) begin
        chk("seg1", seg1, SEGT[dsel(dig1)]);
        chk("seg3", seg3, SEGT[dsel(dig3)]);
      end
    end
    p1      = dig1;
    p3      = dig3;
    lastdig = {al, ah, bl, bh};
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [6:0] seq [4];
    int cnt;
    int dh;
    seq[0] = 7'b1101101; seq[1] = 7'b1111011;
    seq[2] = 7'b0110000; seq[3] = 7'b1111110;
    al = 4'd2; ah = 4'd9; bl = 4'd1; bh = 4'd0;
    ga = 1'b0; gb = 1'b0;
    repeat (3) @(negedge clk);
    release_rst();

    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("seq_seg", seg1, seq[i % 4]);
      chk("seq_dig", dig1, 4'b0001 << (i % 4));
    end

    tick();
    al = 4'hF; ah = 4'hF; bl = 4'hF; bh = 4'hF;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blank1", seg1, 7'b0);
      chk("blank3", seg3, 7'b0);
    end
    tick();
    ah = 4'hA;
    repeat (6) tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dash", seg1, (dig1 == 4'b0010) ? 7'b0000001 : 7'b0);
    end

    tick(); ga = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("a_green", {ag1, br1}, 2'b11);
    repeat (3) tick();
    ga = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (aa1) cnt++;
    end
    chk("amb_len", cnt, AMB);
    chk("all_red", {ar1, br1, ag1, bg1}, 4'b1100);

    tick(); gb = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("b_green", {bg1, ar1}, 2'b11);
    tick(); gb = 1'b0;
    repeat (10) tick();

    ga = 1'b1; gb = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("both_req", {ar1, br1, ag1, bg1}, 4'b1100);
    end
    tick(); gb = 1'b0;
    repeat (3) tick();
    gb = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("a_hold", {ag1, br1, bg1}, 3'b110);
    end

    tick(); ga = 1'b0; gb = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("in_amber", aa1, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_now1", {ar1, aa1, ag1, br1, ba1, bg1}, 6'b100100);
    chk("rst_now3", {ar3, aa3, ag3, br3, ba3, bg3}, 6'b100100);
    ga = 1'b1;
    repeat (100) @(posedge clk);
    release_rst();
    @(posedge clk);
    #1 chk("post_rst_red", ag1, 1'b0);
    @(posedge clk);
    #1 chk("post_rst_go", ag1, 1'b1);

    dh = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) ga = 1'($urandom);
      if ($urandom_range(0, 5) == 0) gb = 1'($urandom);
      dh--;
      if (dh == 0) begin
        al = ($urandom % 2) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        ah = 4'($urandom_range(0, 15));
        bl = 4'($urandom_range(0, 9));
        bh = 4'($urandom_range(0, 15));
        dh = $urandom_range(1, 14);
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 5)) tick();
        release_rst();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
